// File: rtl/rtc_cmd_arbiter.sv
// Two-client round-robin arbiter in front of a DS1302 serial command engine.
// Optional downstream-ack watchdog enabled by defining RTC_ARB_TIMEOUT_EN.
module rtc_cmd_arbiter #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       c0_cmd_read,
   input  logic       c0_cmd_write,
   input  logic [7:0] c0_read_addr,
   input  logic [7:0] c0_write_addr,
   input  logic [7:0] c0_write_data,
   output logic       c0_read_ack,
   output logic       c0_write_ack,
   output logic [7:0] c0_read_data,
   input  logic       c1_cmd_read,
   input  logic       c1_cmd_write,
   input  logic [7:0] c1_read_addr,
   input  logic [7:0] c1_write_addr,
   input  logic [7:0] c1_write_data,
   output logic       c1_read_ack,
   output logic       c1_write_ack,
   output logic [7:0] c1_read_data,
   output logic       cmd_read,
   output logic       cmd_write,
   output logic [7:0] read_addr,
   output logic [7:0] write_addr,
   output logic [7:0] write_data,
   input  logic       cmd_read_ack,
   input  logic       cmd_write_ack,
   input  logic [7:0] read_data,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t          state_q;
   logic            last_grant_q, grant_q, rd_q;
   logic [7:0]      raddr_q, waddr_q, wdata_q;
   logic            cmd_read_q, cmd_write_q, timeout_q;
   logic [1:0]      rack_q, wack_q;
   logic [1:0][7:0] rdata_q;

   logic            pend0, pend1, grant_d, rd_d, ack_match, timeout_hit;
   logic [7:0]      raddr_d, waddr_d, wdata_d, done_data;

   always_comb begin
      pend0 = c0_cmd_read | c0_cmd_write;
      pend1 = c1_cmd_read | c1_cmd_write;
      grant_d = 1'b0;
      if (pend0 && pend1) grant_d = ~last_grant_q;
      else if (pend1)     grant_d = 1'b1;
      // a client asking for both is served as a read; its write stays pending
      rd_d    = grant_d ? c1_cmd_read   : c0_cmd_read;
      raddr_d = grant_d ? c1_read_addr  : c0_read_addr;
      waddr_d = grant_d ? c1_write_addr : c0_write_addr;
      wdata_d = grant_d ? c1_write_data : c0_write_data;
      ack_match = rd_q ? cmd_read_ack : cmd_write_ack;
      done_data = ack_match ? read_data : 8'hFF;
   end

`ifdef RTC_ARB_TIMEOUT_EN
   logic [15:0] tcnt_q;

   always_ff @(posedge sys_clk) begin
      if (rst || state_q != ISSUE) tcnt_q <= 16'd0;
      else                         tcnt_q <= tcnt_q + 16'd1;
   end

   assign timeout_hit = (tcnt_q == TIMEOUT_CYCLES - 16'd1);
`else
   logic [15:0] unused_timeout_cycles;
   assign unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         rd_q         <= 1'b0;
         raddr_q      <= 8'd0;
         waddr_q      <= 8'd0;
         wdata_q      <= 8'd0;
         cmd_read_q   <= 1'b0;
         cmd_write_q  <= 1'b0;
         timeout_q    <= 1'b0;
         rack_q       <= 2'b00;
         wack_q       <= 2'b00;
         rdata_q      <= '0;
      end else begin
         rack_q    <= 2'b00;
         wack_q    <= 2'b00;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pend0 || pend1) begin
                  state_q     <= ISSUE;
                  grant_q     <= grant_d;
                  rd_q        <= rd_d;
                  raddr_q     <= raddr_d;
                  waddr_q     <= waddr_d;
                  wdata_q     <= wdata_d;
                  cmd_read_q  <= rd_d;
                  cmd_write_q <= ~rd_d;
               end
            end
            ISSUE: begin
               if (ack_match || timeout_hit) begin
                  state_q     <= DONE;
                  cmd_read_q  <= 1'b0;
                  cmd_write_q <= 1'b0;
                  timeout_q   <= ~ack_match;
                  if (rd_q) begin
                     rack_q[grant_q]  <= 1'b1;
                     rdata_q[grant_q] <= done_data;
                  end else begin
                     wack_q[grant_q]  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q      <= IDLE;
               last_grant_q <= grant_q;
            end
         endcase
      end
   end

   assign cmd_read     = cmd_read_q;
   assign cmd_write    = cmd_write_q;
   assign read_addr    = (state_q == ISSUE) ? raddr_q : 8'd0;
   assign write_addr   = (state_q == ISSUE) ? waddr_q : 8'd0;
   assign write_data   = (state_q == ISSUE) ? wdata_q : 8'd0;
   assign busy         = (state_q != IDLE);
   assign timeout_err  = timeout_q;
   assign c0_read_ack  = rack_q[0];
   assign c1_read_ack  = rack_q[1];
   assign c0_write_ack = wack_q[0];
   assign c1_write_ack = wack_q[1];
   assign c0_read_data = rdata_q[0];
   assign c1_read_data = rdata_q[1];

endmodule

// File: tb/tb_rtc_cmd_arbiter.sv
// Scoreboard bench for rtc_cmd_arbiter: client drivers, a downstream responder
// and a client-ack monitor. Timeout case runs when RTC_ARB_TIMEOUT_EN is defined.
module tb_rtc_cmd_arbiter;

   logic            sys_clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      crd = '0, cwr = '0;
   logic [1:0][7:0] cra = '0, cwa = '0, cwd = '0;
   logic [1:0]      rack, wack;
   logic [1:0][7:0] rdat;
   logic            cmd_read, cmd_write, busy, timeout_err;
   logic [7:0]      read_addr, write_addr, write_data;
   logic            cmd_read_ack = 1'b0, cmd_write_ack = 1'b0;
   logic [7:0]      read_data = 8'd0;

   int total = 0;
   int bad = 0;

   typedef struct {
      bit         rd;
      logic [7:0] addr;
      logic [7:0] wd;
      int         delay;
      logic [7:0] rdata;
      bit         no_ack;
      int         tlen;
      bit         spur;
   } ds_t;

   typedef struct {
      int         c;
      bit         rd;
      logic [7:0] data;
      bit         terr;
   } cl_t;

   ds_t ds_q[$];
   cl_t cl_q[$];

   always #5 sys_clk = ~sys_clk;

   rtc_cmd_arbiter #(.TIMEOUT_CYCLES(16'd10)) dut (
      .sys_clk(sys_clk), .rst(rst),
      .c0_cmd_read(crd[0]), .c0_cmd_write(cwr[0]),
      .c0_read_addr(cra[0]), .c0_write_addr(cwa[0]), .c0_write_data(cwd[0]),
      .c0_read_ack(rack[0]), .c0_write_ack(wack[0]), .c0_read_data(rdat[0]),
      .c1_cmd_read(crd[1]), .c1_cmd_write(cwr[1]),
      .c1_read_addr(cra[1]), .c1_write_addr(cwa[1]), .c1_write_data(cwd[1]),
      .c1_read_ack(rack[1]), .c1_write_ack(wack[1]), .c1_read_data(rdat[1]),
      .cmd_read(cmd_read), .cmd_write(cmd_write),
      .read_addr(read_addr), .write_addr(write_addr), .write_data(write_data),
      .cmd_read_ack(cmd_read_ack), .cmd_write_ack(cmd_write_ack), .read_data(read_data),
      .busy(busy), .timeout_err(timeout_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Raise levels, drop each one as its ack is seen; returns on the ack negedge.
   task automatic drive(input int c, input bit rd, input bit wr,
                        input logic [7:0] ra, input logic [7:0] wa, input logic [7:0] wd);
      crd[c] = rd; cwr[c] = wr; cra[c] = ra; cwa[c] = wa; cwd[c] = wd;
      for (int i = 0; i < 300 && (crd[c] || cwr[c]); i++) begin
         @(negedge sys_clk);
         if (rack[c]) crd[c] = 1'b0;
         if (wack[c]) cwr[c] = 1'b0;
      end
      if (crd[c] || cwr[c]) begin
         chk("client_ack_wait", 0, 1);
         crd[c] = 1'b0; cwr[c] = 1'b0;
      end
   endtask

   // Downstream responder
   initial begin
      ds_t e;
      int  n;
      forever begin
         @(negedge sys_clk);
         if (!rst && (cmd_read || cmd_write)) begin
            if (ds_q.size() == 0) begin
               chk("unexpected_cmd", 1, 0);
               for (int i = 0; i < 100 && (cmd_read || cmd_write); i++) @(negedge sys_clk);
            end else begin
               e = ds_q.pop_front();
               chk("ds_cmd_read", cmd_read, e.rd);
               chk("ds_cmd_write", cmd_write, !e.rd);
               chk("ds_busy", busy, 1);
               if (e.rd) chk("ds_read_addr", read_addr, e.addr);
               else begin
                  chk("ds_write_addr", write_addr, e.addr);
                  chk("ds_write_data", write_data, e.wd);
               end
               n = 1;
               if (e.no_ack) begin
                  for (int i = 0; i < 200; i++) begin
                     @(negedge sys_clk);
                     if (cmd_read || cmd_write) n++;
                     else break;
                  end
                  if (e.tlen != 0) chk("timeout_cmd_len", n, e.tlen);
               end else begin
                  while (n < e.delay) begin
                     if (e.spur && n == 2) cmd_write_ack = 1'b1;
                     @(negedge sys_clk);
                     cmd_write_ack = 1'b0;
                     chk("ds_cmd_hold", e.rd ? cmd_read : cmd_write, 1);
                     n++;
                  end
                  if (e.rd) begin
                     read_data = e.rdata;
                     cmd_read_ack = 1'b1;
                  end else cmd_write_ack = 1'b1;
                  @(negedge sys_clk);
                  cmd_read_ack = 1'b0; cmd_write_ack = 1'b0; read_data = 8'hEE;
                  chk("ds_cmd_read_clr", cmd_read, 0);
                  chk("ds_cmd_write_clr", cmd_write, 0);
                  chk("ds_idle_fields", {read_addr, write_addr, write_data}, 0);
               end
            end
         end
      end
   end

   // Client-ack monitor
   cl_t me;
   always @(negedge sys_clk) begin
      if (!rst) begin
         if ((rack | wack) != 2'b00) begin
            chk("ack_onehot", $countones({rack, wack}), 1);
            if (cl_q.size() == 0) chk("unexpected_ack", {rack, wack}, 0);
            else begin
               me = cl_q.pop_front();
               chk("ack_client", (rack[1] | wack[1]) ? 1 : 0, me.c);
               chk("ack_type_read", (rack != 2'b00) ? 1 : 0, me.rd);
               if (me.rd) chk("client_read_data", rdat[me.c], me.data);
               chk("ack_timeout_err", timeout_err, me.terr);
               $display("txn client=%0d op=%s rdata=%h terr=%0d",
                        me.c, me.rd ? "rd" : "wr", rdat[me.c], timeout_err);
            end
         end else if (timeout_err) chk("stray_timeout_err", timeout_err, 0);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      rst = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge sys_clk);
      chk("rst_cmd", {cmd_read, cmd_write}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_fields", {read_addr, write_addr, write_data}, 0);
      chk("rst_acks", {rack, wack}, 0);
      chk("rst_rdata", rdat, 0);
      rst = 1'b0;

      // single read, 5-cycle downstream latency
      ds_q.push_back('{1'b1, 8'h81, 8'h00, 5, 8'h59, 1'b0, 0, 1'b0});
      cl_q.push_back('{0, 1'b1, 8'h59, 1'b0});
      drive(0, 1'b1, 1'b0, 8'h81, 8'h00, 8'h00);
      @(negedge sys_clk);
      chk("c1_rdata_untouched", rdat[1], 0);

      // simultaneous after reset: c0 write wins the first tie
      do_reset();
      ds_q.push_back('{1'b0, 8'h10, 8'hA5, 3, 8'h00, 1'b0, 0, 1'b0});
      ds_q.push_back('{1'b1, 8'h22, 8'h00, 2, 8'h33, 1'b0, 0, 1'b0});
      cl_q.push_back('{0, 1'b0, 8'h00, 1'b0});
      cl_q.push_back('{1, 1'b1, 8'h33, 1'b0});
      fork
         drive(0, 1'b0, 1'b1, 8'h00, 8'h10, 8'hA5);
         drive(1, 1'b1, 1'b0, 8'h22, 8'h00, 8'h00);
      join

      // continuous requests from both: grants 0,1,0,1
      ds_q.push_back('{1'b1, 8'h40, 8'h00, 2, 8'hA0, 1'b0, 0, 1'b0});
      ds_q.push_back('{1'b1, 8'h50, 8'h00, 3, 8'hB0, 1'b0, 0, 1'b0});
      ds_q.push_back('{1'b1, 8'h41, 8'h00, 1, 8'hA1, 1'b0, 0, 1'b0});
      ds_q.push_back('{1'b1, 8'h51, 8'h00, 2, 8'hB1, 1'b0, 0, 1'b0});
      cl_q.push_back('{0, 1'b1, 8'hA0, 1'b0});
      cl_q.push_back('{1, 1'b1, 8'hB0, 1'b0});
      cl_q.push_back('{0, 1'b1, 8'hA1, 1'b0});
      cl_q.push_back('{1, 1'b1, 8'hB1, 1'b0});
      fork
         begin
            drive(0, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00);
            drive(0, 1'b1, 1'b0, 8'h41, 8'h00, 8'h00);
         end
         begin
            drive(1, 1'b1, 1'b0, 8'h50, 8'h00, 8'h00);
            drive(1, 1'b1, 1'b0, 8'h51, 8'h00, 8'h00);
         end
      join

      // read and write together: read first, write stays pending
      ds_q.push_back('{1'b1, 8'h0A, 8'h00, 2, 8'h3C, 1'b0, 0, 1'b0});
      ds_q.push_back('{1'b0, 8'h0B, 8'hCC, 2, 8'h00, 1'b0, 0, 1'b0});
      cl_q.push_back('{0, 1'b1, 8'h3C, 1'b0});
      cl_q.push_back('{0, 1'b0, 8'h00, 1'b0});
      drive(0, 1'b1, 1'b1, 8'h0A, 8'h0B, 8'hCC);

      // spurious write ack during a read
      ds_q.push_back('{1'b1, 8'h07, 8'h00, 6, 8'h5A, 1'b0, 0, 1'b1});
      cl_q.push_back('{1, 1'b1, 8'h5A, 1'b0});
      drive(1, 1'b1, 1'b0, 8'h07, 8'h00, 8'h00);

      // reset in the third ISSUE cycle
      ds_q.push_back('{1'b1, 8'h44, 8'h00, 0, 8'h00, 1'b1, 0, 1'b0});
      crd[0] = 1'b1; cra[0] = 8'h44;
      for (int i = 0; i < 50 && !cmd_read; i++) @(negedge sys_clk);
      chk("rst_mid_cmd_seen", cmd_read, 1);
      repeat (2) @(negedge sys_clk);
      rst = 1'b1;
      @(posedge sys_clk);
      #1;
      chk("rst_mid_cmd_read", cmd_read, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_acks", {rack, wack}, 0);
      chk("rst_mid_rdata", rdat, 0);
      crd[0] = 1'b0;
      @(negedge sys_clk);
      rst = 1'b0;
      ds_q.push_back('{1'b0, 8'h30, 8'h77, 2, 8'h00, 1'b0, 0, 1'b0});
      cl_q.push_back('{1, 1'b0, 8'h00, 1'b0});
      drive(1, 1'b0, 1'b1, 8'h00, 8'h30, 8'h77);

`ifdef RTC_ARB_TIMEOUT_EN
      // no downstream ack: abort after 10 ISSUE cycles
      ds_q.push_back('{1'b1, 8'h33, 8'h00, 0, 8'h00, 1'b1, 10, 1'b0});
      cl_q.push_back('{1, 1'b1, 8'hFF, 1'b1});
      drive(1, 1'b1, 1'b0, 8'h33, 8'h00, 8'h00);
`endif

      for (int i = 0; i < 200 && (ds_q.size() != 0 || cl_q.size() != 0); i++)
         @(negedge sys_clk);
      repeat (3) @(negedge sys_clk);
      chk("ds_queue_drained", ds_q.size(), 0);
      chk("cl_queue_drained", cl_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
